// File: rtl/rx_length_decoder.sv
// Receive header decoder: finds the VLAN tag and length/type field, and turns the
// length into padded/actual 64-bit word counts plus enable levels for the data-field counter.
module rx_length_decoder #(
  parameter int MIN_UNTAGGED = 46,
  parameter int MIN_TAGGED   = 42,
  parameter int MAX_LEN      = 1500
) (
  input  logic        rxclk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        word_valid,
  input  logic [63:0] rxd64,
  input  logic        end_data_cnt,
  input  logic        frame_end,
  input  logic        frame_abort,
  output logic        start_data_cnt,
  output logic        start_tagged_cnt,
  output logic        tagged_frame,
  output logic        length_is_type,
  output logic        len_valid,
  output logic [12:0] integer_cnt,
  output logic [12:0] small_integer_cnt,
  output logic [2:0]  data_rem,
  output logic [2:0]  small_rem
);

  typedef enum logic [1:0] {IDLE, HDR1, TAG, DATA} state_t;
  state_t state;

  logic [15:0] fld_hdr, fld_tag, len_sel, min_len, padded;
  logic        is_type;
  logic [12:0] int_nxt, small_nxt;
  logic [2:0]  rem_nxt, small_rem_nxt;
  logic        unused_lanes;

  // Byte 12 (lane 4 of word 1) and byte 16 (lane 0 of word 2) are the field MSBs.
  assign fld_hdr      = {rxd64[39:32], rxd64[47:40]};
  assign fld_tag      = {rxd64[7:0], rxd64[15:8]};
  assign unused_lanes = ^{rxd64[63:48], rxd64[31:16]};

  always_comb begin
    len_sel       = (state == TAG) ? fld_tag : fld_hdr;
    min_len       = (state == TAG) ? 16'(MIN_TAGGED) : 16'(MIN_UNTAGGED);
    padded        = (len_sel < min_len) ? min_len : len_sel;
    is_type       = (len_sel > 16'(MAX_LEN));
    int_nxt       = padded[15:3];
    rem_nxt       = padded[2:0];
    small_nxt     = len_sel[15:3];
    small_rem_nxt = len_sel[2:0];
    if (is_type) begin
      int_nxt       = 13'h1FFF;
      rem_nxt       = 3'd0;
      small_nxt     = 13'h1FFF;
      small_rem_nxt = 3'd0;
    end
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      start_data_cnt    <= 1'b0;
      start_tagged_cnt  <= 1'b0;
      tagged_frame      <= 1'b0;
      length_is_type    <= 1'b0;
      len_valid         <= 1'b0;
      integer_cnt       <= 13'd0;
      small_integer_cnt <= 13'd0;
      data_rem          <= 3'd0;
      small_rem         <= 3'd0;
    end else begin
      len_valid <= 1'b0;
      if (frame_abort && state != IDLE) begin
        state            <= IDLE;
        start_data_cnt   <= 1'b0;
        start_tagged_cnt <= 1'b0;
        tagged_frame     <= 1'b0;
      end else if (frame_start && word_valid) begin
        state            <= HDR1;
        start_data_cnt   <= 1'b0;
        start_tagged_cnt <= 1'b0;
        tagged_frame     <= 1'b0;
        length_is_type   <= 1'b0;
      end else begin
        case (state)
          HDR1, TAG: begin
            if (frame_end) begin
              state <= IDLE;
            end else if (word_valid) begin
              if (state == HDR1 && fld_hdr == 16'h8100) begin
                tagged_frame <= 1'b1;
                state        <= TAG;
              end else begin
                state             <= DATA;
                start_data_cnt    <= 1'b1;
                start_tagged_cnt  <= (state == TAG);
                length_is_type    <= is_type;
                len_valid         <= 1'b1;
                integer_cnt       <= int_nxt;
                data_rem          <= rem_nxt;
                small_integer_cnt <= small_nxt;
                small_rem         <= small_rem_nxt;
              end
            end
          end
          DATA: begin
            // A type frame has no meaningful data length, so the counter's end is ignored.
            if (frame_end || (end_data_cnt && !length_is_type)) begin
              state            <= IDLE;
              start_data_cnt   <= 1'b0;
              start_tagged_cnt <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rx_length_decoder.sv
// Directed bench for rx_length_decoder: untagged, tagged, type, abort, restart and reset cases.
module tb_rx_length_decoder;

  logic        rxclk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_start = 1'b0;
  logic        word_valid = 1'b0;
  logic [63:0] rxd64 = 64'd0;
  logic        end_data_cnt = 1'b0;
  logic        frame_end = 1'b0;
  logic        frame_abort = 1'b0;
  logic        start_data_cnt, start_tagged_cnt, tagged_frame, length_is_type, len_valid;
  logic [12:0] integer_cnt, small_integer_cnt;
  logic [2:0]  data_rem, small_rem;

  int checks = 0;
  int errors = 0;

  rx_length_decoder dut (
    .rxclk(rxclk), .reset(reset), .frame_start(frame_start), .word_valid(word_valid),
    .rxd64(rxd64), .end_data_cnt(end_data_cnt), .frame_end(frame_end),
    .frame_abort(frame_abort), .start_data_cnt(start_data_cnt),
    .start_tagged_cnt(start_tagged_cnt), .tagged_frame(tagged_frame),
    .length_is_type(length_is_type), .len_valid(len_valid), .integer_cnt(integer_cnt),
    .small_integer_cnt(small_integer_cnt), .data_rem(data_rem), .small_rem(small_rem)
  );

  always #5 rxclk = ~rxclk;

  task automatic step();
    @(posedge rxclk);
    #1;
  endtask

  task automatic drive(input logic fs, input logic wv, input logic [63:0] d);
    frame_start = fs;
    word_valid  = wv;
    rxd64       = d;
  endtask

  function automatic logic [63:0] w1(input logic [15:0] f);
    return {16'hDEAD, f[7:0], f[15:8], 32'h1234_5678};
  endfunction

  function automatic logic [63:0] w2(input logic [15:0] l);
    return {48'hCAFE_F00D_9999, l[7:0], l[15:8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_counts(input string tag, input int ic, input int dr, input int sc, input int sr);
    chk({tag, "_int"}, 32'(integer_cnt), ic);
    chk({tag, "_drem"}, 32'(data_rem), dr);
    chk({tag, "_small"}, 32'(small_integer_cnt), sc);
    chk({tag, "_srem"}, 32'(small_rem), sr);
  endtask

  task automatic pulse_end();
    frame_end = 1'b1;
    drive(1'b0, 1'b0, 64'd0);
    step();
    frame_end = 1'b0;
  endtask

  initial begin
    step();
    step();
    reset = 1'b0;
    chk("rst_start", 32'(start_data_cnt), 0);
    chk("rst_tagcnt", 32'(start_tagged_cnt), 0);
    chk("rst_tagged", 32'(tagged_frame), 0);
    chk("rst_type", 32'(length_is_type), 0);
    chk("rst_lv", 32'(len_valid), 0);
    chk_counts("rst", 0, 0, 0, 0);
    step();

    // Untagged L=100
    drive(1'b1, 1'b1, 64'h0011_2233_4455_6677);
    step();
    chk("a_hdr_start", 32'(start_data_cnt), 0);
    drive(1'b0, 1'b1, w1(16'd100));
    step();
    chk("a_start", 32'(start_data_cnt), 1);
    chk("a_tagcnt", 32'(start_tagged_cnt), 0);
    chk("a_lv", 32'(len_valid), 1);
    chk_counts("a", 12, 4, 12, 4);
    drive(1'b0, 1'b0, 64'd0);
    step();
    chk("a_lv_pulse", 32'(len_valid), 0);
    chk("a_hold", 32'(start_data_cnt), 1);
    end_data_cnt = 1'b1;
    step();
    end_data_cnt = 1'b0;
    chk("a_end", 32'(start_data_cnt), 0);

    // Untagged L=20 with padding; end_data_cnt in HDR1 must be ignored
    drive(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    drive(1'b0, 1'b0, 64'd0);
    end_data_cnt = 1'b1;
    step();
    end_data_cnt = 1'b0;
    drive(1'b0, 1'b1, w1(16'd20));
    step();
    chk("b_start", 32'(start_data_cnt), 1);
    chk_counts("b", 5, 6, 2, 4);
    pulse_end();
    chk("b_end", 32'(start_data_cnt), 0);

    // Tagged L=30, two stall cycles in TAG
    drive(1'b1, 1'b1, 64'h0102_0304_0506_0708);
    step();
    drive(1'b0, 1'b1, w1(16'h8100));
    step();
    chk("c_tagged", 32'(tagged_frame), 1);
    chk("c_nostart", 32'(start_data_cnt), 0);
    drive(1'b0, 1'b0, w2(16'd99));
    step();
    step();
    chk("c_stall_start", 32'(start_data_cnt), 0);
    chk("c_stall_lv", 32'(len_valid), 0);
    drive(1'b0, 1'b1, w2(16'd30));
    step();
    chk("c_start", 32'(start_data_cnt), 1);
    chk("c_tagcnt", 32'(start_tagged_cnt), 1);
    chk("c_lv", 32'(len_valid), 1);
    chk_counts("c", 5, 2, 3, 6);
    pulse_end();
    chk("c_end_tagcnt", 32'(start_tagged_cnt), 0);

    // Type frame 0x0800
    drive(1'b1, 1'b1, 64'd0);
    step();
    chk("d_tag_clr", 32'(tagged_frame), 0);
    drive(1'b0, 1'b1, w1(16'h0800));
    step();
    chk("d_type", 32'(length_is_type), 1);
    chk_counts("d", 8191, 0, 8191, 0);
    drive(1'b0, 1'b0, 64'd0);
    end_data_cnt = 1'b1;
    step();
    end_data_cnt = 1'b0;
    chk("d_edc_ignored", 32'(start_data_cnt), 1);
    pulse_end();
    chk("d_end", 32'(start_data_cnt), 0);

    // L=1500 then abort
    drive(1'b1, 1'b1, 64'd0);
    step();
    drive(1'b0, 1'b1, w1(16'd1500));
    step();
    chk("e_type", 32'(length_is_type), 0);
    chk_counts("e", 187, 4, 187, 4);
    drive(1'b0, 1'b0, 64'd0);
    frame_abort = 1'b1;
    step();
    frame_abort = 1'b0;
    chk("e_abort", 32'(start_data_cnt), 0);
    chk("e_hold_cnt", 32'(integer_cnt), 187);

    // L=46 after the abort, then restart from DATA with L=64
    drive(1'b1, 1'b1, 64'd0);
    step();
    drive(1'b0, 1'b1, w1(16'd46));
    step();
    chk("f_start", 32'(start_data_cnt), 1);
    chk_counts("f", 5, 6, 5, 6);
    drive(1'b1, 1'b1, 64'h5555_5555_5555_5555);
    step();
    chk("g_restart_drop", 32'(start_data_cnt), 0);
    drive(1'b0, 1'b1, w1(16'd64));
    step();
    chk("g_start", 32'(start_data_cnt), 1);
    chk("g_lv", 32'(len_valid), 1);
    chk_counts("g", 8, 0, 8, 0);

    // Async reset while in TAG
    drive(1'b1, 1'b1, 64'd0);
    step();
    drive(1'b0, 1'b1, w1(16'h8100));
    step();
    chk("h_tagged", 32'(tagged_frame), 1);
    drive(1'b0, 1'b0, 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("h_rst_tagged", 32'(tagged_frame), 0);
    chk("h_rst_int", 32'(integer_cnt), 0);
    chk("h_rst_small", 32'(small_integer_cnt), 0);
    chk("h_rst_start", 32'(start_data_cnt), 0);
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
